// File: rtl/cpu_apb_master.sv
// Per-CPU APB master traffic generator: writes a pattern into a CPU-private window, reads it back, counts mismatches.
// Optional ACCESS-phase timeout is enabled with `define CPU_APB_TIMEOUT_EN.

package cpu_apb_master_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

endpackage

module cpu_apb_master
  import cpu_apb_master_pkg::*;
#(
  parameter int unsigned NUM_TXN        = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] CPU_STRIDE     = 32'h0001_0000,
  parameter int unsigned IDLE_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_index,
  output apb_req_t    o_apb_m_req,
  input  apb_resp_t   i_apb_m_resp,
  output logic        o_apb_m_psel,
  output logic        o_apb_m_penable,
  input  logic        i_apb_m_pready,
  output logic        o_done,
  output logic [15:0] o_err_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TXN - 1);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state, state_n;
  logic [31:0]      win_base, win_base_n;
  logic [7:0]       idx8, idx8_n;
  logic [CNT_W-1:0] txn_idx, txn_idx_n;
  logic             rd_phase, rd_phase_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [15:0]      err_count_n;
  logic             done_n, psel_n, penable_n;
  apb_req_t         req_n;
  logic             err_inc, finish, abort;

  logic [31:0]      base_c;
  logic [31:0]      expected_c;
  logic             gap_exit_c;
  logic [CNT_W-1:0] adv_idx_c;
  logic             adv_rd_c, adv_done_c;

`ifdef CPU_APB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt, to_cnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Request for transaction i in the given phase; reads carry no data or strobes.
  function automatic apb_req_t build_req(input logic rd, input logic [31:0] base,
                                         input logic [7:0] id8, input logic [CNT_W-1:0] i);
    apb_req_t r;
    r        = '0;
    r.paddr  = base + {14'd0, i, 2'b00};
    r.pwrite = ~rd;
    if (!rd) begin
      r.pwdata = {id8, 8'hA5, i};
      r.pstrb  = 4'hF;
    end
    return r;
  endfunction

  // Window base is taken straight from cpu_index while INIT latches it.
  assign base_c     = (state == S_INIT) ? (BASE_ADDR + cpu_index * CPU_STRIDE) : win_base;
  assign expected_c = {idx8, 8'hA5, txn_idx};
  assign gap_exit_c = ({24'd0, gap_cnt} + 32'd1) >= IDLE_CYCLES;

  // Index/phase after the current transaction retires.
  always_comb begin
    adv_idx_c  = txn_idx + 16'd1;
    adv_rd_c   = rd_phase;
    adv_done_c = 1'b0;
    if (txn_idx == LAST_IDX) begin
      adv_idx_c = '0;
      if (rd_phase) adv_done_c = 1'b1;
      else          adv_rd_c   = 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    win_base_n = win_base;
    idx8_n     = idx8;
    txn_idx_n  = txn_idx;
    rd_phase_n = rd_phase;
    gap_cnt_n  = gap_cnt;
    done_n     = o_done;
    psel_n     = o_apb_m_psel;
    penable_n  = o_apb_m_penable;
    req_n      = o_apb_m_req;
    err_inc    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
`ifdef CPU_APB_TIMEOUT_EN
    to_cnt_n   = to_cnt;
`endif

    case (state)
      S_INIT: begin
        win_base_n = base_c;
        idx8_n     = cpu_index[7:0];
        txn_idx_n  = '0;
        rd_phase_n = 1'b0;
        gap_cnt_n  = '0;
        if (IDLE_CYCLES == 0) begin
          state_n   = S_SETUP;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          req_n     = build_req(1'b0, base_c, cpu_index[7:0], '0);
        end else begin
          state_n = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_exit_c) begin
          state_n   = S_SETUP;
          gap_cnt_n = '0;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          req_n     = build_req(rd_phase, win_base, idx8, txn_idx);
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end

      S_SETUP: begin
        state_n   = S_ACCESS;
        penable_n = 1'b1;
`ifdef CPU_APB_TIMEOUT_EN
        to_cnt_n  = '0;
`endif
      end

      S_ACCESS: begin
        if (i_apb_m_pready) begin
          finish  = 1'b1;
          err_inc = rd_phase ? ((i_apb_m_resp.prdata != expected_c) || i_apb_m_resp.pslverr)
                             : i_apb_m_resp.pslverr;
        end
`ifdef CPU_APB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          finish  = 1'b1;
          abort   = 1'b1;
          err_inc = 1'b1;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
`endif
        if (finish) begin
          txn_idx_n  = adv_idx_c;
          rd_phase_n = adv_rd_c;
          penable_n  = 1'b0;
          if (adv_done_c) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            psel_n  = 1'b0;
          end else if ((IDLE_CYCLES == 0) && !abort) begin
            state_n = S_SETUP;
            psel_n  = 1'b1;
            req_n   = build_req(adv_rd_c, win_base, idx8, adv_idx_c);
          end else begin
            // An abandoned transfer always drops psel for at least one cycle.
            state_n   = S_GAP;
            gap_cnt_n = '0;
            psel_n    = 1'b0;
          end
        end
      end

      S_DONE: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end

      default: state_n = S_INIT;
    endcase

    err_count_n = (err_inc && (o_err_count != 16'hFFFF)) ? (o_err_count + 16'd1) : o_err_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_INIT;
      win_base        <= '0;
      idx8            <= '0;
      txn_idx         <= '0;
      rd_phase        <= 1'b0;
      gap_cnt         <= '0;
      o_done          <= 1'b0;
      o_err_count     <= '0;
      o_apb_m_psel    <= 1'b0;
      o_apb_m_penable <= 1'b0;
      o_apb_m_req     <= '0;
`ifdef CPU_APB_TIMEOUT_EN
      to_cnt          <= '0;
`endif
    end else begin
      state           <= state_n;
      win_base        <= win_base_n;
      idx8            <= idx8_n;
      txn_idx         <= txn_idx_n;
      rd_phase        <= rd_phase_n;
      gap_cnt         <= gap_cnt_n;
      o_done          <= done_n;
      o_err_count     <= err_count_n;
      o_apb_m_psel    <= psel_n;
      o_apb_m_penable <= penable_n;
      o_apb_m_req     <= req_n;
`ifdef CPU_APB_TIMEOUT_EN
      to_cnt          <= to_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_apb_master.sv
// Directed bench for cpu_apb_master: echo-memory APB responder, transaction log, table of expected transfers.
module tb_cpu_apb_master;
  import cpu_apb_master_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cpu_index;
  apb_req_t    req;
  apb_resp_t   resp;
  logic        psel, penable, pready, done;
  logic [15:0] err_count;

  apb_req_t    req2;
  apb_resp_t   resp2;
  logic        psel2, penable2, done2;
  logic [15:0] err2;
  logic [31:0] cpu_index2 = 32'd1;
  logic        pready2    = 1'b1;

  cpu_apb_master #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .cpu_index(cpu_index),
    .o_apb_m_req(req), .i_apb_m_resp(resp),
    .o_apb_m_psel(psel), .o_apb_m_penable(penable), .i_apb_m_pready(pready),
    .o_done(done), .o_err_count(err_count));

  cpu_apb_master #(.NUM_TXN(4), .IDLE_CYCLES(0)) u_b2b (
    .clk(clk), .rst(rst), .cpu_index(cpu_index2),
    .o_apb_m_req(req2), .i_apb_m_resp(resp2),
    .o_apb_m_psel(psel2), .o_apb_m_penable(penable2), .i_apb_m_pready(pready2),
    .o_done(done2), .o_err_count(err2));

  // Responder controls
  int   stall_seq = -1;
  int   stall_len = 0;
  logic corrupt_en = 1'b0;
  logic slverr_en  = 1'b0;

  logic [31:0] mem  [0:63];
  logic [31:0] mem2 [0:63];

  // Transaction log, one entry per SETUP cycle
  logic [6:0]  n_setup;
  logic        wr_log   [0:127];
  logic [31:0] addr_log [0:127];
  logic [31:0] data_log [0:127];
  logic [3:0]  strb_log [0:127];
  int          acc_log  [0:127];
  int          cur_acc, unstable, edge_cnt, done_edge, done2_edge;
  int          b2b_setups, b2b_access, b2b_gaps;
  logic        b2b_started;
  apb_req_t    snap;

  always_comb begin
    resp.prdata = mem[req.paddr[7:2]];
    if (corrupt_en && !req.pwrite && (req.paddr[7:2] == 6'd3)) resp.prdata = '0;
    resp.pslverr = slverr_en && req.pwrite && (req.paddr[7:2] == 6'd7);
    resp2.prdata  = mem2[req2.paddr[7:2]];
    resp2.pslverr = 1'b0;
  end

  assign pready = !(psel && penable && ((int'(n_setup) - 1) == stall_seq) && (cur_acc < stall_len));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_setup     <= '0;
      cur_acc     <= 0;
      unstable    <= 0;
      edge_cnt    <= 0;
      done_edge   <= -1;
      done2_edge  <= -1;
      b2b_setups  <= 0;
      b2b_access  <= 0;
      b2b_gaps    <= 0;
      b2b_started <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (done && done_edge < 0)   done_edge  <= edge_cnt;
      if (done2 && done2_edge < 0) done2_edge <= edge_cnt;
      if (psel && !penable) begin
        wr_log[n_setup]   <= req.pwrite;
        addr_log[n_setup] <= req.paddr;
        data_log[n_setup] <= req.pwdata;
        strb_log[n_setup] <= req.pstrb;
        acc_log[n_setup]  <= 0;
        snap              <= req;
        n_setup           <= n_setup + 7'd1;
        cur_acc           <= 0;
      end
      if (psel && penable) begin
        acc_log[n_setup - 7'd1] <= acc_log[n_setup - 7'd1] + 1;
        cur_acc <= cur_acc + 1;
        if (req != snap) unstable <= unstable + 1;
      end
      if (psel && penable && pready && req.pwrite) mem[req.paddr[7:2]] <= req.pwdata;
      if (psel2 && !penable2) b2b_setups <= b2b_setups + 1;
      if (psel2 && penable2)  b2b_access <= b2b_access + 1;
      if (psel2) b2b_started <= 1'b1;
      else if (b2b_started && !done2) b2b_gaps <= b2b_gaps + 1;
      if (psel2 && penable2 && req2.pwrite) mem2[req2.paddr[7:2]] <= req2.pwdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          run;
    int          seq;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          acc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check_run(input int run);
    check($sformatf("run%0d_setups", run), 128'(n_setup), 128'd32);
    for (int k = 0; k < NV; k++) begin
      if (vecs[k].run == run) begin
        logic [6:0] s;
        s = 7'(vecs[k].seq);
        check($sformatf("run%0d_seq%0d_req", run, vecs[k].seq),
              {wr_log[s], addr_log[s], data_log[s], strb_log[s]},
              {vecs[k].wr, vecs[k].addr, vecs[k].data, vecs[k].strb});
        check($sformatf("run%0d_seq%0d_access_cycles", run, vecs[k].seq),
              128'(acc_log[s]), 128'(vecs[k].acc));
      end
    end
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound && !done; k++) @(negedge clk);
    check("done_reached", 128'(done), 128'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic restart(input logic [31:0] idx);
    @(negedge clk);
    rst = 1'b1;
    cpu_index = idx;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0,  0, 1'b1, 32'h0002_0000, 32'h02A5_0000, 4'hF, 1};
    vecs[1]  = '{0,  1, 1'b1, 32'h0002_0004, 32'h02A5_0001, 4'hF, 1};
    vecs[2]  = '{0,  7, 1'b1, 32'h0002_001C, 32'h02A5_0007, 4'hF, 1};
    vecs[3]  = '{0, 15, 1'b1, 32'h0002_003C, 32'h02A5_000F, 4'hF, 1};
    vecs[4]  = '{0, 16, 1'b0, 32'h0002_0000, 32'h0000_0000, 4'h0, 1};
    vecs[5]  = '{0, 19, 1'b0, 32'h0002_000C, 32'h0000_0000, 4'h0, 1};
    vecs[6]  = '{0, 31, 1'b0, 32'h0002_003C, 32'h0000_0000, 4'h0, 1};
    vecs[7]  = '{1,  0, 1'b1, 32'h0005_0000, 32'h05A5_0000, 4'hF, 1};
    vecs[8]  = '{1, 15, 1'b1, 32'h0005_003C, 32'h05A5_000F, 4'hF, 1};
    vecs[9]  = '{1, 18, 1'b0, 32'h0005_0008, 32'h0000_0000, 4'h0, 6};
    vecs[10] = '{1, 31, 1'b0, 32'h0005_003C, 32'h0000_0000, 4'h0, 1};
    vecs[11] = '{3, 16, 1'b0, 32'h0002_0000, 32'h0000_0000, 4'h0, 8};
    vecs[12] = '{3, 17, 1'b0, 32'h0002_0004, 32'h0000_0000, 4'h0, 1};

    rst = 1'b1;
    cpu_index = 32'd2;
    repeat (2) @(negedge clk);
    check("reset_state", {psel, penable, done, err_count, req}, '0);

    // Clean run, cpu 2, pready always high
    rst = 1'b0;
    wait_done(400);
    check_run(0);
    check("done_latency", 128'(done_edge), 128'd97);
    check("clean_err_count", 128'(err_count), 128'd0);
    check("clean_unstable", 128'(unstable), 128'd0);
    check("b2b_done_latency", 128'(done2_edge), 128'd17);
    check("b2b_psel_gaps", 128'(b2b_gaps), 128'd0);
    check("b2b_setup_cycles", 128'(b2b_setups), 128'd8);
    check("b2b_access_cycles", 128'(b2b_access), 128'd8);
    check("b2b_err_count", 128'(err2), 128'd0);
    repeat (5) @(negedge clk);
    check("done_sticky", {done, psel, penable}, 3'b100);

    // Stall read 2 for 5 cycles; reset asynchronously in the middle of it
    stall_seq = 18;
    stall_len = 5;
    restart(32'd2);
    for (int k = 0; k < 400 && !(n_setup == 7'd19 && psel && penable); k++) @(negedge clk);
    check("stall_reached", {n_setup, psel, penable}, {7'd19, 2'b11});
    #2 rst = 1'b1;
    #1;
    check("async_reset_psel", 128'(psel), 128'd0);
    check("async_reset_penable", 128'(penable), 128'd0);
    check("async_reset_paddr", 128'(req.paddr), 128'd0);
    cpu_index = 32'd5;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cpu_index = 32'd9;
    wait_done(400);
    check_run(1);
    check("stall_unstable", 128'(unstable), 128'd0);
    check("stall_err_count", 128'(err_count), 128'd0);

    // Corrupted read 3 and slave error on write 7
    stall_seq  = -1;
    corrupt_en = 1'b1;
    slverr_en  = 1'b1;
    restart(32'd2);
    for (int k = 0; k < 400 && n_setup < 7'd17; k++) @(negedge clk);
    check("err_after_writes", 128'(err_count), 128'd1);
    wait_done(400);
    check("err_at_done", 128'(err_count), 128'd2);
    corrupt_en = 1'b0;
    slverr_en  = 1'b0;

`ifdef CPU_APB_TIMEOUT_EN
    // pready stuck low on read 0
    stall_seq = 16;
    stall_len = 1000;
    restart(32'd2);
    wait_done(600);
    check_run(3);
    check("timeout_err_count", 128'(err_count), 128'd1);
    stall_seq = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
